// File: rtl/hz_meter.sv
// hz_meter: measures period and high time (in clk cycles) of a slow asynchronous square wave.
// Latency: a sig_in rise sampled at posedge n shows as meas_valid sampled at posedge n+SYNC_STAGES+1.
// Backpressure: none; results are single-cycle pulses that must be captured when meas_valid is high.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      asynchronous active-low clear
//   sig_in     asynchronous square wave under measurement
//   period_out cycles between the last two accepted rising edges
//   high_out   high cycles within that period
//   meas_valid 1-cycle pulse, period_out/high_out just updated
//   glitch     1-cycle pulse, a period shorter than MIN_PERIOD was rejected
//   no_signal  level, no accepted measurement since reset or since the last timeout
module hz_meter #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 28,
  parameter int TIMEOUT_CYC = 200_000_000,
  parameter int MIN_PERIOD  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             glitch,
  output logic             no_signal
);

  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] MIN_V     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] ONE_V     = CNT_W'(1);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  // Front end: synchronizer chain plus one history flop for edge detection.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev_q;
  logic                   s;
  logic                   rise;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      s_prev_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_prev_q <= s;
    end
  end

  // Counters restart at 1 on the edge cycle so that on the next edge cycle they
  // hold exactly the period and the number of high cycles within it.
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;

  always_comb begin
    run_cnt_d  = run_cnt_q;
    high_cnt_d = high_cnt_q;
    if (rise) begin
      run_cnt_d  = ONE_V;
      high_cnt_d = ONE_V;
    end else begin
      if (run_cnt_q < TIMEOUT_V) begin
        run_cnt_d = run_cnt_q + ONE_V;
      end
      if (s && (high_cnt_q != '1)) begin
        high_cnt_d = high_cnt_q + ONE_V;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt_q  <= '0;
      high_cnt_q <= '0;
    end else begin
      run_cnt_q  <= run_cnt_d;
      high_cnt_q <= high_cnt_d;
    end
  end

  // Measurement FSM with registered outputs.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             meas_valid_q, meas_valid_d;
  logic             glitch_q, glitch_d;
  logic             no_signal_q, no_signal_d;

  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    high_d       = high_q;
    meas_valid_d = 1'b0;
    glitch_d     = 1'b0;
    no_signal_d  = no_signal_q;
    case (state_q)
      IDLE: begin
        // First edge after reset/timeout only opens the window; the partial
        // period before it carries no usable measurement.
        if (rise) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        // A rise on the same cycle the timeout threshold is reached wins.
        if (rise) begin
          if (run_cnt_q >= MIN_V) begin
            period_d     = run_cnt_q;
            high_d       = high_cnt_q;
            meas_valid_d = 1'b1;
            no_signal_d  = 1'b0;
          end else begin
            glitch_d = 1'b1;
          end
        end else if (run_cnt_q == TIMEOUT_V) begin
          no_signal_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      glitch_q     <= 1'b0;
      no_signal_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      high_q       <= high_d;
      meas_valid_q <= meas_valid_d;
      glitch_q     <= glitch_d;
      no_signal_q  <= no_signal_d;
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign meas_valid = meas_valid_q;
  assign glitch     = glitch_q;
  assign no_signal  = no_signal_q;

endmodule

// File: tb/tb_hz_meter.sv
// Bench for hz_meter: directed waveforms plus random periods, checked every cycle
// against a sample-index reference model (periods from rise-index differences).
module tb_hz_meter;

  localparam int CW   = 28;
  localparam int TO   = 1000;
  localparam int MINP = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sig_in = 1'b0;
  logic [CW-1:0] period_out;
  logic [CW-1:0] high_out;
  logic          meas_valid;
  logic          glitch;
  logic          no_signal;

  always #5 clk = ~clk;

  hz_meter #(
    .SYNC_STAGES(2),
    .CNT_W      (CW),
    .TIMEOUT_CYC(TO),
    .MIN_PERIOD (MINP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .period_out(period_out),
    .high_out  (high_out),
    .meas_valid(meas_valid),
    .glitch    (glitch),
    .no_signal (no_signal)
  );

  typedef struct {
    int per;
    int hi;
    bit mv;
    bit gl;
    bit ns;
  } exp_t;

  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference model state, indexed by the posedge at which sig_in was sampled.
  int   k;
  int   last_rise;
  int   hicnt;
  bit   measuring;
  bit   prev;
  exp_t cur;
  exp_t pipe [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    k         = 0;
    last_rise = 0;
    hicnt     = 0;
    measuring = 1'b0;
    prev      = 1'b0;
    cur.per   = 0;
    cur.hi    = 0;
    cur.mv    = 1'b0;
    cur.gl    = 1'b0;
    cur.ns    = 1'b1;
    for (int i = 0; i < 3; i++) pipe[i] = cur;
  endtask

  // One sample of sig_in; the outcome appears on the DUT outputs two posedges later.
  task automatic model_step(input bit v);
    exp_t o;
    int   p;
    o    = cur;
    o.mv = 1'b0;
    o.gl = 1'b0;
    if (v && !prev) begin
      if (measuring) begin
        p = k - last_rise;
        if (p >= MINP) begin
          o.per = p;
          o.hi  = hicnt;
          o.mv  = 1'b1;
          o.ns  = 1'b0;
        end else begin
          o.gl = 1'b1;
        end
      end
      measuring = 1'b1;
      last_rise = k;
      hicnt     = 1;
    end else begin
      if (v) hicnt++;
      if (measuring && (k - last_rise == TO)) begin
        measuring = 1'b0;
        o.ns      = 1'b1;
      end
    end
    prev    = v;
    k++;
    cur     = o;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = o;
  endtask

  // Called at a negedge: drive, clock, model, then compare at the following negedge.
  task automatic step(input bit v);
    sig_in = v;
    @(posedge clk);
    model_step(v);
    @(negedge clk);
    chk("period_out", 32'(period_out), pipe[2].per);
    chk("high_out",   32'(high_out),   pipe[2].hi);
    chk("meas_valid", 32'(meas_valid), 32'(pipe[2].mv));
    chk("glitch",     32'(glitch),     32'(pipe[2].gl));
    chk("no_signal",  32'(no_signal),  32'(pipe[2].ns));
  endtask

  task automatic wave(input int per, input int hi, input int n);
    repeat (n) begin
      repeat (hi) step(1'b1);
      repeat (per - hi) step(1'b0);
    end
  endtask

  // Asserted while clk is low so the clear is seen without any clock edge.
  task automatic apply_reset(input bit v);
    #2;
    reset  = 1'b0;
    sig_in = v;
    #1;
    chk("rst_period_out", 32'(period_out), 0);
    chk("rst_high_out",   32'(high_out),   0);
    chk("rst_meas_valid", 32'(meas_valid), 0);
    chk("rst_glitch",     32'(glitch),     0);
    chk("rst_no_signal",  32'(no_signal),  1);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int p;
    int h;

    // 1: period 100 / high 50 from reset
    apply_reset(1'b0);
    wave(100, 50, 4);
    chk("t1_period", 32'(period_out), 100);
    chk("t1_high",   32'(high_out),   50);
    chk("t1_nosig",  32'(no_signal),  0);

    // 2: duty change, then period change
    wave(100, 25, 3);
    chk("t2_high25", 32'(high_out), 25);
    wave(40, 30, 3);
    chk("t2_period40", 32'(period_out), 40);
    chk("t2_high30",   32'(high_out),   30);

    // 3: stop low past timeout, then resume
    repeat (1100) step(1'b0);
    chk("t3_timeout", 32'(no_signal), 1);
    wave(100, 50, 1);
    chk("t3_first_edge_silent", 32'(no_signal), 1);
    repeat (3) step(1'b1);
    chk("t3_resume_nosig",  32'(no_signal),  0);
    chk("t3_resume_period", 32'(period_out), 100);

    // 4: extra rise 3 cycles after an edge, next edge 97 later
    repeat (47) step(1'b1);
    repeat (50) step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    chk("t4_glitch", 32'(glitch), 1);
    repeat (44) step(1'b1);
    repeat (50) step(1'b0);
    repeat (3) step(1'b1);
    chk("t4_period97", 32'(period_out), 97);
    chk("t4_high47",   32'(high_out),   47);
    repeat (47) step(1'b1);
    repeat (50) step(1'b0);

    // 5: reset mid-period with sig_in high
    repeat (30) step(1'b1);
    apply_reset(1'b1);
    repeat (20) step(1'b1);
    repeat (50) step(1'b0);
    wave(100, 50, 2);

    // 6: held high from reset
    apply_reset(1'b1);
    repeat (1100) step(1'b1);
    chk("t6_nosig", 32'(no_signal), 1);

    // Timeout boundary: period == TO is still measured, period TO+1 times out
    apply_reset(1'b0);
    wave(1000, 10, 2);
    repeat (3) step(1'b1);
    chk("to_eq_period", 32'(period_out), 1000);
    chk("to_eq_nosig",  32'(no_signal),  0);
    repeat (7) step(1'b1);
    repeat (991) step(1'b0);
    repeat (3) step(1'b1);
    chk("to_over_nosig",  32'(no_signal),  1);
    chk("to_over_period", 32'(period_out), 1000);
    repeat (7) step(1'b1);
    repeat (40) step(1'b0);

    // Random periods, including occasional glitch-length periods
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        p = $urandom_range(2, 3);
        h = 1;
      end else begin
        p = $urandom_range(4, 80);
        h = $urandom_range(1, p - 1);
      end
      wave(p, h, 1);
    end
    repeat (1010) step(1'b0);
    for (int i = 0; i < 20; i++) begin
      p = $urandom_range(4, 120);
      h = $urandom_range(1, p - 1);
      wave(p, h, 1);
    end
    repeat (5) step(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
